// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one DMI request/response channel between NREQ
// requesters. Round-robin grant, exactly one outstanding transaction,
// responses routed back to the issuing requester. A response watchdog
// synthesizes an error response (resp=2, data=0) if the debug module
// stalls, and the late response is swallowed when it eventually arrives.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_req_*                per-requester request channels (packed slices)
//   in_resp_*               per-requester response valid/ready, shared bits
//   out_req_*               request channel to the debug module
//   out_resp_*              response channel from the debug module
//   busy                    any state but IDLE, or a late response pending
//   grant_id                current / last granted requester
//   timeout_cnt             saturating count of watchdog timeouts
module dmi_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           in_req_valid,
  output logic [NREQ-1:0]           in_req_ready,
  input  logic [7*NREQ-1:0]         in_req_bits_addr,
  input  logic [2*NREQ-1:0]         in_req_bits_op,
  input  logic [32*NREQ-1:0]        in_req_bits_data,
  output logic [NREQ-1:0]           in_resp_valid,
  input  logic [NREQ-1:0]           in_resp_ready,
  output logic [1:0]                in_resp_bits_resp,
  output logic [31:0]               in_resp_bits_data,
  output logic                      out_req_valid,
  input  logic                      out_req_ready,
  output logic [6:0]                out_req_bits_addr,
  output logic [1:0]                out_req_bits_op,
  output logic [31:0]               out_req_bits_data,
  input  logic                      out_resp_valid,
  output logic                      out_resp_ready,
  input  logic [1:0]                out_resp_bits_resp,
  input  logic [31:0]               out_resp_bits_data,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [7:0]                timeout_cnt
);

  localparam int          GW = $clog2(NREQ);
  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {IDLE, REQ, RESP, TERR} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   grant_q, grant_n;
  logic [GW-1:0]   rr_q, rr_n;
  logic            drop_q, drop_n;
  logic [CW-1:0]   wd_q, wd_n;
  logic [7:0]      tcnt_q, tcnt_n;

  // Per-requester views of the packed request buses.
  logic [6:0]  addr_a [NREQ];
  logic [1:0]  op_a   [NREQ];
  logic [31:0] data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = in_req_bits_addr[7*i +: 7];
    assign op_a[i]   = in_req_bits_op[2*i +: 2];
    assign data_a[i] = in_req_bits_data[32*i +: 32];
  end

  // Cyclic search for the first valid requester at or after rr_q.
  logic          found;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = GW'((32'(rr_q) + i) % NR);
      if (!found && in_req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n           = state;
    grant_n           = grant_q;
    rr_n              = rr_q;
    drop_n            = drop_q;
    wd_n              = wd_q;
    tcnt_n            = tcnt_q;
    in_req_ready      = '0;
    in_resp_valid     = '0;
    in_resp_bits_resp = '0;
    in_resp_bits_data = '0;
    out_req_valid     = 1'b0;
    out_req_bits_addr = '0;
    out_req_bits_op   = '0;
    out_req_bits_data = '0;
    // A pending late response is consumed in every state.
    out_resp_ready    = drop_q;

    if (drop_q && out_resp_valid) drop_n = 1'b0;

    case (state)
      IDLE: begin
        if (found && !drop_q) begin
          grant_n = pick;
          rr_n    = (pick == GW'(NREQ-1)) ? '0 : pick + GW'(1);
          state_n = REQ;
        end
      end
      REQ: begin
        out_req_valid          = 1'b1;
        out_req_bits_addr      = addr_a[grant_q];
        out_req_bits_op        = op_a[grant_q];
        out_req_bits_data      = data_a[grant_q];
        in_req_ready[grant_q]  = out_req_ready;
        if (out_req_ready) begin
          state_n = RESP;
          wd_n    = '0;
        end
      end
      RESP: begin
        in_resp_valid[grant_q] = out_resp_valid;
        out_resp_ready         = drop_q | in_resp_ready[grant_q];
        in_resp_bits_resp      = out_resp_bits_resp;
        in_resp_bits_data      = out_resp_bits_data;
        // A handshake on the final watchdog cycle wins over the timeout.
        if (out_resp_valid && in_resp_ready[grant_q]) begin
          state_n = IDLE;
        end else if (wd_q == CW'(TIMEOUT-1)) begin
          state_n = TERR;
          drop_n  = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_n = tcnt_q + 8'd1;
        end else begin
          wd_n = wd_q + CW'(1);
        end
      end
      TERR: begin
        in_resp_valid[grant_q] = 1'b1;
        in_resp_bits_resp      = 2'd2;
        if (in_resp_ready[grant_q]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      rr_q    <= rr_n;
      drop_q  <= drop_n;
      wd_q    <= wd_n;
      tcnt_q  <= tcnt_n;
    end
  end

  assign busy        = (state != IDLE) || drop_q;
  assign grant_id    = grant_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
module tb_dmi_arbiter;
  localparam int N = 3;
  localparam int T = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    in_req_valid;
  logic [N-1:0]    in_req_ready;
  logic [7*N-1:0]  in_req_bits_addr;
  logic [2*N-1:0]  in_req_bits_op;
  logic [32*N-1:0] in_req_bits_data;
  logic [N-1:0]    in_resp_valid;
  logic [N-1:0]    in_resp_ready;
  logic [1:0]      in_resp_bits_resp;
  logic [31:0]     in_resp_bits_data;
  logic            out_req_valid;
  logic            out_req_ready;
  logic [6:0]      out_req_bits_addr;
  logic [1:0]      out_req_bits_op;
  logic [31:0]     out_req_bits_data;
  logic            out_resp_valid;
  logic            out_resp_ready;
  logic [1:0]      out_resp_bits_resp;
  logic [31:0]     out_resp_bits_data;
  logic            busy;
  logic [1:0]      grant_id;
  logic [7:0]      timeout_cnt;

  dmi_arbiter #(.NREQ(N), .TIMEOUT(T), .CW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
    .in_req_bits_addr(in_req_bits_addr), .in_req_bits_op(in_req_bits_op),
    .in_req_bits_data(in_req_bits_data),
    .in_resp_valid(in_resp_valid), .in_resp_ready(in_resp_ready),
    .in_resp_bits_resp(in_resp_bits_resp), .in_resp_bits_data(in_resp_bits_data),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
    .out_req_bits_addr(out_req_bits_addr), .out_req_bits_op(out_req_bits_op),
    .out_req_bits_data(out_req_bits_data),
    .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready),
    .out_resp_bits_resp(out_resp_bits_resp), .out_resp_bits_data(out_resp_bits_data),
    .busy(busy), .grant_id(grant_id), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: round-robin pointer and timeout counter.
  int rr   = 0;
  int tcnt = 0;

  logic [6:0]  ra [N];
  logic [1:0]  ro [N];
  logic [31:0] rd [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int mask);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (rr + i) % N;
      if (mask[k]) return k;
    end
    return 0;
  endfunction

  task automatic load_reqs;
    for (int i = 0; i < N; i++) begin
      ra[i] = 7'($urandom);
      ro[i] = 2'($urandom);
      rd[i] = $urandom;
      in_req_bits_addr[7*i +: 7]  = ra[i];
      in_req_bits_op[2*i +: 2]    = ro[i];
      in_req_bits_data[32*i +: 32] = rd[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out_req_valid"}, 32'(out_req_valid), 0);
    check({tag, ".in_req_ready"}, 32'(in_req_ready), 0);
    check({tag, ".in_resp_valid"}, 32'(in_resp_valid), 0);
    check({tag, ".out_resp_ready"}, 32'(out_resp_ready), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".grant_id"}, 32'(grant_id), 0);
    check({tag, ".timeout_cnt"}, 32'(timeout_cnt), 0);
    check({tag, ".resp_bits"}, {in_resp_bits_resp, in_resp_bits_data[29:0]}, 0);
    check({tag, ".req_bits"}, {out_req_bits_addr, out_req_bits_op, out_req_bits_data[22:0]}, 0);
  endtask

  // One full transaction. mask: requesters presenting a request; bp: cycles
  // of out_req_ready backpressure; d: response delay in RESP cycles (d>=T
  // means the debug module stalls); h: cycles the requester holds off
  // in_resp_ready in TERR; l: cycle offset (from TERR entry) of the late response.
  task automatic run_txn(input int mask, input int bp, input int d, input int h, input int l);
    int g;
    int c0;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    g  = rr_pick(mask);
    rr = (g + 1) % N;
    load_reqs();
    in_req_valid   = 3'(mask);
    out_req_ready  = 1'b0;
    out_resp_valid = 1'b0;
    in_resp_ready  = '0;
    @(negedge clk);
    check("idle.out_req_valid", 32'(out_req_valid), 0);
    check("idle.busy", 32'(busy), 0);
    tick();
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check("bp.out_req_valid", 32'(out_req_valid), 1);
      check("bp.addr", 32'(out_req_bits_addr), 32'(ra[g]));
      check("bp.op", 32'(out_req_bits_op), 32'(ro[g]));
      check("bp.data", out_req_bits_data, rd[g]);
      check("bp.in_req_ready", 32'(in_req_ready), 0);
      check("bp.grant_id", 32'(grant_id), 32'(g));
      tick();
    end
    out_req_ready = 1'b1;
    @(negedge clk);
    check("req.out_req_valid", 32'(out_req_valid), 1);
    check("req.addr", 32'(out_req_bits_addr), 32'(ra[g]));
    check("req.op", 32'(out_req_bits_op), 32'(ro[g]));
    check("req.data", out_req_bits_data, rd[g]);
    check("req.in_req_ready", 32'(in_req_ready), 32'(1 << g));
    check("req.grant_id", 32'(grant_id), 32'(g));
    tick();
    in_req_valid  = '0;
    out_req_ready = 1'b0;
    if (d < T) begin
      for (int k = 0; k < d; k++) begin
        in_resp_ready = 3'($urandom);
        @(negedge clk);
        check("wait.in_resp_valid", 32'(in_resp_valid), 0);
        check("wait.out_resp_ready", 32'(out_resp_ready), 32'(in_resp_ready[g]));
        check("wait.busy", 32'(busy), 1);
        tick();
      end
      exp_resp = 2'($urandom);
      exp_data = $urandom;
      in_resp_ready      = 3'($urandom) | 3'(1 << g);
      out_resp_valid     = 1'b1;
      out_resp_bits_resp = exp_resp;
      out_resp_bits_data = exp_data;
      @(negedge clk);
      check("resp.in_resp_valid", 32'(in_resp_valid), 32'(1 << g));
      check("resp.resp", 32'(in_resp_bits_resp), 32'(exp_resp));
      check("resp.data", in_resp_bits_data, exp_data);
      check("resp.out_resp_ready", 32'(out_resp_ready), 1);
      tick();
      out_resp_valid = 1'b0;
      in_resp_ready  = '0;
      @(negedge clk);
      check("done.busy", 32'(busy), 0);
      check("done.timeout_cnt", 32'(timeout_cnt), 32'(tcnt));
      check("done.grant_id", 32'(grant_id), 32'(g));
      tick();
    end else begin
      for (int k = 0; k < T; k++) begin
        @(negedge clk);
        check("stall.in_resp_valid", 32'(in_resp_valid), 0);
        check("stall.out_resp_ready", 32'(out_resp_ready), 0);
        check("stall.busy", 32'(busy), 1);
        tick();
      end
      if (tcnt < 255) tcnt++;
      c0 = ((h > l) ? h : l) + 1;
      for (int r = 0; r <= c0; r++) begin
        bit terr;
        bit drop;
        terr = (r <= h);
        drop = (r <= l);
        in_resp_ready      = (r >= h) ? '1 : '0;
        out_resp_valid     = (r == l);
        out_resp_bits_resp = 2'd1;
        out_resp_bits_data = 32'h1234;
        in_req_valid       = (r < c0) ? '1 : '0;
        @(negedge clk);
        check("terr.in_resp_valid", 32'(in_resp_valid), terr ? 32'(1 << g) : 0);
        check("terr.resp", 32'(in_resp_bits_resp), terr ? 2 : 0);
        check("terr.data", in_resp_bits_data, 0);
        check("terr.out_resp_ready", 32'(out_resp_ready), 32'(drop));
        check("terr.busy", 32'(busy), 32'(terr | drop));
        check("terr.no_new_req", 32'(out_req_valid), 0);
        check("terr.timeout_cnt", 32'(timeout_cnt), 32'(tcnt));
        tick();
      end
      out_resp_valid = 1'b0;
      in_req_valid   = '0;
      in_resp_ready  = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n            = 1'b0;
    in_req_valid       = '0;
    in_req_bits_addr   = '0;
    in_req_bits_op     = '0;
    in_req_bits_data   = '0;
    in_resp_ready      = '0;
    out_req_ready      = 1'b0;
    out_resp_valid     = 1'b0;
    out_resp_bits_resp = '0;
    out_resp_bits_data = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Single request, immediate response.
    run_txn(3'b001, 0, 0, 0, 0);
    // Contention: requesters 0 and 1 continuously.
    for (int i = 0; i < 4; i++) run_txn(3'b011, 0, 1, 0, 0);
    // Backpressure on the request channel.
    run_txn(3'b110, 5, 2, 0, 0);
    // Watchdog timeout, late response in TERR and after TERR.
    run_txn(3'b001, 0, T, 0, 2);
    run_txn(3'b100, 0, T, 2, 0);
    run_txn(3'b010, 0, T, 3, 3);
    // Response on the last watchdog cycle is delivered.
    run_txn(3'b010, 0, T-1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int m;
      m = int'($urandom_range(1, 7));
      run_txn(m, int'($urandom_range(0, 3)), int'($urandom_range(0, T+1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    // Drive timeout_cnt into saturation.
    for (int i = 0; i < 256; i++) run_txn(3'b001 << (i % 3), 0, T, 0, 0);
    check("sat.timeout_cnt", 32'(timeout_cnt), 255);

    // Asynchronous reset while in RESP.
    rr = 0;
    run_txn(3'b001, 0, 0, 0, 0);
    load_reqs();
    in_req_valid  = 3'b001;
    out_req_ready = 1'b1;
    tick();
    tick();
    in_req_valid       = '0;
    out_req_ready      = 1'b0;
    out_resp_valid     = 1'b1;
    out_resp_bits_resp = 2'd3;
    out_resp_bits_data = 32'hCAFEF00D;
    in_resp_ready      = '0;
    @(negedge clk);
    check("prerst.in_resp_valid", 32'(in_resp_valid), 1);
    check("prerst.data", in_resp_bits_data, 32'hCAFEF00D);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    out_resp_valid = 1'b0;
    reset_n        = 1'b1;
    rr   = 0;
    tcnt = 0;
    run_txn(3'b011, 0, 1, 0, 0);
    run_txn(3'b011, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
